harmonic_scheduler: RTL and testbench
=====================================

HARMONIC_SCHEDULER -- requirements
Module: harmonic_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SAMPLE_INTERVAL, 1500, clocks per output sample.
- SAMPLE_RATE, 48000, phase modulus.
- NUM_HARMONICS, 8, harmonics per sample (1..255).
- LUT_SHIFT, 5, phase-to-LUT-address right shift.
- SCALE_STEP, 20, per-harmonic amplitude decrement.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock in 1: single system clock, rising edge.
- rstn in 1: asynchronous active-low reset.
- frequency in 16: fundamental phase increment, latched at each sample start.
- sp_addr out 8: sample-position RAM address (harmonic index).
- sp_write out 1: RAM write enable.
- sp_writedata out 16: new phase for the RAM.
- sp_readdata in 16: RAM read data, valid 1 cycle after sp_addr.
- lut_addr out 11: sine LUT address. LUT data is valid 2 cycles later.
- adder_start out 1: 1-cycle pulse to the scaling adder.
- adder_clear out 1: 1-cycle accumulator clear.
- adder_mult out 7: scale numerator.
- adder_ready in 1: adder idle/done.
- adder_total in 32: signed accumulator.
- sample_out out 16: DAC-ready sample.
- sample_valid out 1: 1-cycle pulse when sample_out updates.
- busy out 1: high whenever state != IDLE.

Function
REQ-003 The free-running timer SHALL count 0..SAMPLE_INTERVAL-1 and assert internal tick when the count is SAMPLE_INTERVAL-1.
REQ-004 The FSM SHALL have exactly these states: IDLE, READ, CALC, WRITE, WAIT_ADD, FINISH.
REQ-005 IDLE + tick SHALL do all of the following, then go to READ:
- harmonic=0.
- freq_inc = min(frequency, SAMPLE_RATE-1).
- f_lat = that clamped value.
- adder_mult=127.
- adder_clear pulsed 1 cycle.
REQ-006 READ SHALL drive sp_addr=harmonic, then go to CALC after 1 cycle.
REQ-007 CALC SHALL compute pos = sp_readdata + freq_inc using 17 bits, subtract SAMPLE_RATE once if the sum is >= SAMPLE_RATE, then go to WRITE.
REQ-008 WRITE SHALL do all of the following for 1 cycle, then go to WAIT_ADD:
- sp_write=1.
- sp_writedata=pos.
- lut_addr = pos >> LUT_SHIFT.
REQ-009 WAIT_ADD SHALL wait at least 2 cycles after WRITE and until adder_ready=1, then in one cycle do all of the following:
- pulse adder_start.
- decrement adder_mult by SCALE_STEP, saturating at 0.
- freq_inc += f_lat, with a single conditional subtract of SAMPLE_RATE.
- harmonic += 1.
REQ-010 After the start for harmonic NUM_HARMONICS-1, WAIT_ADD SHALL go to FINISH; otherwise it SHALL go to READ.
REQ-011 FINISH SHALL ignore adder_ready on its first cycle; once adder_ready=1 it SHALL do all of the following, then go to IDLE:
- sample_out = (adder_total + 32'h1FFFF)[17:2].
- pulse sample_valid.
REQ-012 sp_write and adder_start SHALL never be high outside WRITE and WAIT_ADD respectively.
REQ-013 A phase at or above SAMPLE_RATE SHALL never be written to the RAM.

Reset
REQ-014 On rstn=0, asynchronously, the following SHALL be 0: timer, harmonic, sp_write, adder_start, adder_clear, sample_valid, busy, sample_out, lut_addr, sp_addr.
REQ-015 On rstn=0, adder_mult SHALL be 127 and the FSM SHALL be in IDLE.
REQ-016 Reset mid-sequence SHALL abandon the sample without a RAM write; the first tick after release restarts at harmonic 0.

Configuration
REQ-017 With OVERRUN_DETECT_EN defined, a tick outside IDLE SHALL be ignored:
- the current sample completes.
- sticky output overrun (1 bit) is set.
- output overrun_count (8 bits, saturating at 255) increments.
- both clear only on reset.
REQ-018 Without OVERRUN_DETECT_EN, a tick outside IDLE SHALL abort the sequence and restart per REQ-005, and the overrun ports SHALL be absent.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- frequency=1000, RAM all 0 -> first sample writes phases 1000, 2000 ... 8000 to addresses 0..7; lut_addr = 31, 62 ... 250.
- frequency=47000, RAM[0]=47000 -> phase 46000 is written; no value >= 48000 is ever written.
- adder_ready held low 50 cycles in WAIT_ADD -> no adder_start until ready; adder_mult sequence 127, 107, 87 ... 0 (saturated).
- adder_total=0 in FINISH -> sample_out=16'h7FFF and sample_valid is a 1-cycle pulse.
- SAMPLE_INTERVAL=20 with adder_ready stuck low -> with macro, overrun=1 and overrun_count increments per tick; without macro, harmonic returns to 0 at each tick.
- rstn pulsed low during WAIT_ADD -> all outputs at their reset values immediately; clean restart on the next tick.

Source files
------------

// File: rtl/harmonic_scheduler.sv
// Additive-synthesis sequencer: per sample, advances each harmonic's phase in RAM, feeds the sine LUT and scaling adder, emits one rounded DAC sample.
// Optional OVERRUN_DETECT_EN: ticks arriving mid-sample are ignored and counted instead of restarting the sequence.
module harmonic_scheduler #(
    parameter int SAMPLE_INTERVAL = 1500,
    parameter int SAMPLE_RATE     = 48000,
    parameter int NUM_HARMONICS   = 8,
    parameter int LUT_SHIFT       = 5,
    parameter int SCALE_STEP      = 20
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic [15:0] frequency,
    output logic [7:0]  sp_addr,
    output logic        sp_write,
    output logic [15:0] sp_writedata,
    input  logic [15:0] sp_readdata,
    output logic [10:0] lut_addr,
    output logic        adder_start,
    output logic        adder_clear,
    output logic [6:0]  adder_mult,
    input  logic        adder_ready,
    input  logic [31:0] adder_total,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        busy
`ifdef OVERRUN_DETECT_EN
    ,
    output logic        overrun,
    output logic [7:0]  overrun_count
`endif
);

    // state    | meaning
    // IDLE     | waiting for tick        READ  | RAM address out   CALC   | phase advance
    // WRITE    | RAM write + LUT addr    WAIT_ADD | LUT latency, adder handshake   FINISH | round result
    typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, WAIT_ADD, FINISH} state_t;

    localparam int            TW     = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_INTERVAL - 1);
    localparam logic [16:0]   RATE   = 17'(SAMPLE_RATE);
    localparam logic [15:0]   F_MAX  = 16'(SAMPLE_RATE - 1);
    localparam logic [7:0]    H_LAST = 8'(NUM_HARMONICS - 1);
    localparam logic [7:0]    STEP   = 8'(SCALE_STEP);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          tick;
    logic          restart;
    logic          armed;
    logic          fin_fire;
    logic [7:0]    harmonic;
    logic [15:0]   freq_inc;
    logic [15:0]   f_lat;
    logic [15:0]   pos;
    logic [15:0]   freq_clamp;
    logic [16:0]   pos_sum;
    logic [15:0]   pos_calc;
    logic [16:0]   step_sum;
    logic [15:0]   step_calc;

    assign tick = (timer == T_LAST);

`ifdef OVERRUN_DETECT_EN
    assign restart = tick && (state == IDLE);
`else
    assign restart = tick;
`endif

    assign freq_clamp = ({1'b0, frequency} >= RATE) ? F_MAX : frequency;
    assign pos_sum    = {1'b0, sp_readdata} + {1'b0, freq_inc};
    assign pos_calc   = (pos_sum >= RATE) ? 16'(pos_sum - RATE) : pos_sum[15:0];
    assign step_sum   = {1'b0, freq_inc} + {1'b0, f_lat};
    assign step_calc  = (step_sum >= RATE) ? 16'(step_sum - RATE) : step_sum[15:0];
    assign fin_fire   = (state == FINISH) && armed && adder_ready;

    assign sp_addr      = harmonic;
    assign sp_writedata = pos;
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sp_write    = 1'b0;
        adder_start = 1'b0;
        adder_clear = 1'b0;
        if (restart) begin
            state_nxt   = READ;
            adder_clear = 1'b1;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                READ:  state_nxt = CALC;
                CALC:  state_nxt = WRITE;
                WRITE: begin
                    sp_write  = 1'b1;
                    state_nxt = WAIT_ADD;
                end
                WAIT_ADD: begin
                    if (armed && adder_ready) begin
                        adder_start = 1'b1;
                        state_nxt   = (harmonic == H_LAST) ? FINISH : READ;
                    end
                end
                FINISH: if (fin_fire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // armed goes high after the first cycle spent in WAIT_ADD/FINISH, covering LUT latency
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            timer        <= '0;
            harmonic     <= '0;
            freq_inc     <= '0;
            f_lat        <= '0;
            pos          <= '0;
            lut_addr     <= '0;
            adder_mult   <= 7'd127;
            armed        <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            timer        <= tick ? '0 : timer + TW'(1);
            armed        <= (state_nxt == state) && ((state == WAIT_ADD) || (state == FINISH));
            sample_valid <= 1'b0;
            if (restart) begin
                harmonic   <= '0;
                freq_inc   <= freq_clamp;
                f_lat      <= freq_clamp;
                adder_mult <= 7'd127;
            end else begin
                if (state == CALC) begin
                    pos      <= pos_calc;
                    lut_addr <= 11'(pos_calc >> LUT_SHIFT);
                end
                if (adder_start) begin
                    adder_mult <= ({1'b0, adder_mult} > STEP) ? 7'({1'b0, adder_mult} - STEP) : 7'd0;
                    freq_inc   <= step_calc;
                    harmonic   <= harmonic + 8'd1;
                end
                if (fin_fire) begin
                    sample_out   <= 16'((adder_total + 32'h0001_FFFF) >> 2);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

`ifdef OVERRUN_DETECT_EN
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
            if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Scoreboard bench for harmonic_scheduler: a phase-arithmetic reference model queues expected RAM writes,
// adder scales and samples; a negedge monitor pops and compares as the DUT presents them.
module tb_harmonic_scheduler;
    localparam int SI = 200;
    localparam int SR = 48000;
    localparam int NH = 8;
    localparam int LS = 5;
    localparam int SS = 20;

    logic        clock;
    logic        rstn;
    logic [15:0] frequency;
    logic [7:0]  sp_addr;
    logic        sp_write;
    logic [15:0] sp_writedata;
    logic [15:0] sp_readdata;
    logic [10:0] lut_addr;
    logic        adder_start;
    logic        adder_clear;
    logic [6:0]  adder_mult;
    logic        adder_ready;
    logic [31:0] adder_total;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
`ifdef OVERRUN_DETECT_EN
    logic        overrun;
    logic [7:0]  overrun_count;
`endif

    harmonic_scheduler #(
        .SAMPLE_INTERVAL(SI), .SAMPLE_RATE(SR), .NUM_HARMONICS(NH),
        .LUT_SHIFT(LS), .SCALE_STEP(SS)
    ) dut (
        .clock(clock), .rstn(rstn), .frequency(frequency),
        .sp_addr(sp_addr), .sp_write(sp_write), .sp_writedata(sp_writedata),
        .sp_readdata(sp_readdata), .lut_addr(lut_addr),
        .adder_start(adder_start), .adder_clear(adder_clear), .adder_mult(adder_mult),
        .adder_ready(adder_ready), .adder_total(adder_total),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy)
`ifdef OVERRUN_DETECT_EN
        , .overrun(overrun), .overrun_count(overrun_count)
`endif
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
        logic [10:0] l;
    } wr_t;

    wr_t         wq[$];
    logic [6:0]  mq[$];
    logic [15:0] sq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_wr = -100;
    logic prev_valid = 1'b0;

    logic [15:0] ram[0:255];
    logic [15:0] ram_init[0:255];
    logic        ram_load;
    int          mram[0:255];

    int   rdy_mode;
    logic rdy_force;
    int   low_run = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
        end else if (sp_write) begin
            ram[sp_addr] <= sp_writedata;
        end
        sp_readdata <= ram[sp_addr];
    end

    // adder model: ready either forced or randomly dropped for at most two cycles
    always @(posedge clock) begin
        #1;
        if (rdy_mode == 0) begin
            adder_ready = rdy_force;
        end else if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
            adder_ready = 1'b1;
            low_run = 0;
        end else begin
            adder_ready = 1'b0;
            low_run++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
    endtask

    // reference: harmonic h advances by (h+1)*f modulo the sample rate
    task automatic model_sample(input int f, input logic [31:0] tot, input int aborts);
        int fc;
        int p;
        int m;
        wr_t e;
        logic [31:0] r;
        fc = (f > SR - 1) ? SR - 1 : f;
        for (int k = 0; k < aborts; k++) begin
            p = (mram[0] + fc) % SR;
            mram[0] = p;
            e.a = 8'd0; e.d = 16'(p); e.l = 11'(p >> LS);
            wq.push_back(e);
        end
        for (int h = 0; h < NH; h++) begin
            p = (mram[h] + ((h + 1) * fc) % SR) % SR;
            mram[h] = p;
            e.a = 8'(h); e.d = 16'(p); e.l = 11'(p >> LS);
            wq.push_back(e);
            m = 127 - SS * h;
            mq.push_back(7'((m < 0) ? 0 : m));
        end
        r = tot + 32'h0001_FFFF;
        sq.push_back(r[17:2]);
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (rstn) begin
            if (sp_write) begin
                last_wr = cyc;
                check("wr_range", 32'(sp_writedata < 16'(SR)), 1);
                if (wq.size() == 0) miss("wr_extra");
                else begin
                    e = wq.pop_front();
                    check("wr_addr", sp_addr, e.a);
                    check("wr_data", sp_writedata, e.d);
                    check("lut_addr", lut_addr, e.l);
                end
            end
            if (adder_start) begin
                check("start_ready", adder_ready, 1);
                check("start_gap", 32'((cyc - last_wr) >= 2), 1);
                if (mq.size() == 0) miss("start_extra");
                else check("adder_mult", adder_mult, mq.pop_front());
            end
            if (sample_valid) begin
                check("valid_pulse", prev_valid, 0);
                if (sq.size() == 0) miss("sample_extra");
                else check("sample_out", sample_out, sq.pop_front());
            end
            prev_valid = sample_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic load_ram();
        ram_load = 1'b1;
        @(posedge clock);
        #1;
        ram_load = 1'b0;
    endtask

    task automatic set_ram(input bit rnd);
        int v;
        for (int i = 0; i < 256; i++) begin
            v = rnd ? int'($urandom_range(0, SR - 1)) : 0;
            ram_init[i] = 16'(v);
            mram[i] = v;
        end
    endtask

    task automatic wait_sample(input int lim);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sample_valid && n < lim);
        check("sample_seen", sample_valid, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_write(input int lim);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sp_write && n < lim);
        check("write_seen", sp_write, 1);
    endtask

    task automatic check_reset();
        check("rst_sp_write", sp_write, 0);
        check("rst_adder_start", adder_start, 0);
        check("rst_adder_clear", adder_clear, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_sp_addr", sp_addr, 0);
        check("rst_adder_mult", adder_mult, 127);
`ifdef OVERRUN_DETECT_EN
        check("rst_overrun", overrun, 0);
        check("rst_overrun_count", overrun_count, 0);
`endif
    endtask

    initial begin
        int f;
        int nstart;
        logic [31:0] tot;
        rstn = 1'b0;
        frequency = '0;
        adder_total = '0;
        ram_load = 1'b0;
        rdy_mode = 0;
        rdy_force = 1'b1;
        adder_ready = 1'b1;
        set_ram(0);
        @(posedge clock);
        #1;
        load_ram();
        @(negedge clock);
        check_reset();

        // RAM zero, 1 kHz step, zero total -> 0x7FFF
        frequency = 16'd1000;
        adder_total = 32'd0;
        model_sample(1000, 32'd0, 0);
        @(negedge clock);
        rstn = 1'b1;
        wait_sample(SI + 200);

        // phase wrap at top of range
        set_ram(1);
        ram_init[0] = 16'd47000;
        mram[0] = 47000;
        load_ram();
        frequency = 16'd47000;
        adder_total = 32'h0001_2345;
        model_sample(47000, 32'h0001_2345, 0);
        wait_sample(SI + 200);

        // adder held busy for 50 cycles in WAIT_ADD
        rdy_force = 1'b0;
        frequency = 16'd3000;
        adder_total = 32'hFFFF_0000;
        model_sample(3000, 32'hFFFF_0000, 0);
        wait_write(SI + 50);
        nstart = 0;
        repeat (50) begin
            @(negedge clock);
            if (adder_start) nstart++;
        end
        check("no_start_while_low", nstart, 0);
        @(posedge clock);
        #1;
        rdy_force = 1'b1;
        wait_sample(SI + 200);

        // randomized samples with a jittery adder
        rdy_mode = 1;
        for (int s = 0; s < 6; s++) begin
            f = int'($urandom_range(0, 65535));
            tot = $urandom;
            frequency = 16'(f);
            adder_total = tot;
            model_sample(f, tot, 0);
            wait_sample(SI + 200);
        end

        // adder stuck across three ticks
        rdy_mode = 0;
        rdy_force = 1'b0;
        f = int'($urandom_range(1, SR - 1));
        frequency = 16'(f);
        adder_total = 32'h0000_4000;
`ifdef OVERRUN_DETECT_EN
        model_sample(f, 32'h0000_4000, 0);
`else
        model_sample(f, 32'h0000_4000, 3);
`endif
        wait_write(SI + 50);
        repeat (3 * SI) @(negedge clock);
        @(posedge clock);
        #1;
        rdy_force = 1'b1;
        wait_sample(SI);
`ifdef OVERRUN_DETECT_EN
        check("overrun", overrun, 1);
        check("overrun_count", overrun_count, 3);
`endif

        // reset in WAIT_ADD abandons the sample
        rdy_force = 1'b0;
        frequency = 16'd500;
        model_sample(500, 32'd0, 0);
        wait_write(SI + 50);
        repeat (3) @(negedge clock);
        #2;
        rstn = 1'b0;
        #1;
        check_reset();
        wq.delete();
        mq.delete();
        sq.delete();
        rdy_mode = 1;
        set_ram(1);
        @(posedge clock);
        #1;
        load_ram();
        f = int'($urandom_range(0, 65535));
        tot = $urandom;
        frequency = 16'(f);
        adder_total = tot;
        model_sample(f, tot, 0);
        @(negedge clock);
        rstn = 1'b1;
        wait_sample(SI + 200);

        check("wq_drained", wq.size(), 0);
        check("mq_drained", mq.size(), 0);
        check("sq_drained", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
